stream_handshake_monitor: RTL and testbench
===========================================

// Module: stream_handshake_monitor
// PURPOSE
//  Inline pass-through monitor placed directly downstream of ready_valid_delay (or any
//  ready/valid source). Forwards the handshake combinationally unchanged.
//  Counts transfers and stall cycles and tracks the longest stall run. Flags protocol
//  violations: valid dropped before handshake, payload changed while stalled, stall timeout.
// PARAMETERS
//  payload_t      logic  type of the forwarded payload; compared with == for change detect
//  CntWidth       32     width of all statistic counters (>=2)
//  TimeoutCycles  0      stall run length that raises timeout_o; 0 = timeout disabled
// PORTS
//  clk_i                 in   1          clock
//  rst_ni                in   1          asynchronous reset, active-low
//  clear_i               in   1          sync clear of counters and sticky flags
//  valid_i               in   1          upstream valid
//  ready_o               out  1          upstream ready (= ready_i)
//  payload_i             in   payload_t  upstream payload
//  valid_o               out  1          downstream valid (= valid_i)
//  ready_i               in   1          downstream ready
//  payload_o             out  payload_t  downstream payload (= payload_i)
//  transfers_o           out  CntWidth   number of valid&ready cycles
//  stall_cycles_o        out  CntWidth   number of valid&!ready cycles
//  max_stall_o           out  CntWidth   longest completed-or-ongoing stall run
//  err_valid_drop_o      out  1          sticky: valid deasserted while pending
//  err_payload_change_o  out  1          sticky: payload changed while pending
//  timeout_o             out  1          sticky: stall run reached TimeoutCycles
// BEHAVIOUR
//  - Datapath: valid_o/ready_o/payload_o purely combinational; zero latency; the monitor
//    never alters or blocks the handshake. Statistic outputs are registered and update
//    the cycle after the event.
//  - Reset: state=Idle, all counters 0, run counter 0, all flags 0, latched payload 0.
//  - FSM (2 states):
//    Idle:    valid_i&ready_i -> transfers+1, stay Idle.
//             valid_i&!ready_i -> latch payload_i, run=1, stall+1, go Pending.
//    Pending: !valid_i -> set err_valid_drop_o, run=0, go Idle.
//             valid_i&payload_i!=latched -> set err_payload_change_o, relatch payload_i.
//             valid_i&ready_i -> transfers+1, run=0, go Idle (same-cycle change still flags).
//             valid_i&!ready_i -> stall+1, run+1, stay Pending.
//  - max_stall_o <= run value whenever the incremented run exceeds it (tracks live run).
//  - timeout_o set when TimeoutCycles!=0 and incremented run == TimeoutCycles; sticky.
//  - All counters (transfers, stall, run, max) saturate at 2**CntWidth-1; no wrap.
//  - clear_i: counters, max_stall and all sticky flags -> 0 next cycle; clear wins over
//    a same-cycle increment/flag set. FSM state and latched payload unaffected; run
//    counter also -> 0 so a stall spanning clear restarts at 0 and counts from next cycle.
//  - Async reset mid-stall: everything returns to reset values; no flags raised.
//  - ready_i without valid_i has no effect on any counter or state.
// TESTING
//  1 Five back-to-back beats, ready_i=1 -> transfers_o=5, stall_cycles_o=0, flags 0.
//  2 valid held 3 cycles with ready_i=0, then ready_i=1 -> stall=3, max_stall=3,
//    transfers=1; outputs mirror inputs every cycle.
//  3 valid_i=1,ready_i=0 for 1 cycle then valid_i=0 -> err_valid_drop_o=1 stays 1
//    until clear_i; transfers=0.
//  4 Stalled beat payload 8'hA5 changes to 8'h5A before ready -> err_payload_change_o=1.
//  5 TimeoutCycles=4, stall 4 cycles -> timeout_o=1 on cycle after 4th stall; 3 -> 0.
//  6 CntWidth=2, 5 transfers -> transfers_o=3 (saturated); clear_i with a
//    transfer same cycle -> transfers_o=0.

Source files
------------

// File: rtl/stream_handshake_monitor.sv
// Zero-latency ready/valid pass-through that gathers transfer/stall statistics
// and raises sticky flags on handshake protocol violations.
module stream_handshake_monitor #(
   parameter type         payload_t     = logic,
   parameter int unsigned CntWidth      = 32,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  payload_t            payload_i,
   output logic                valid_o,
   input  logic                ready_i,
   output payload_t            payload_o,
   output logic [CntWidth-1:0] transfers_o,
   output logic [CntWidth-1:0] stall_cycles_o,
   output logic [CntWidth-1:0] max_stall_o,
   output logic                err_valid_drop_o,
   output logic                err_payload_change_o,
   output logic                timeout_o
);

   typedef enum logic {Idle, Pending} state_e;

   // Timeout threshold widened so that values beyond the counter range can never match.
   localparam int unsigned          ExtW       = CntWidth + 32;
   localparam logic [ExtW-1:0]      TimeoutExt = ExtW'(TimeoutCycles);

   state_e              state_q, state_d;
   payload_t            latched_q, latched_d;
   logic [CntWidth-1:0] transfers_q, transfers_d;
   logic [CntWidth-1:0] stall_q, stall_d;
   logic [CntWidth-1:0] run_q, run_d;
   logic [CntWidth-1:0] max_q, max_d;
   logic                err_drop_q, err_drop_d;
   logic                err_chg_q, err_chg_d;
   logic                timeout_q, timeout_d;
   logic                stall_evt;

   function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
      return (&v) ? v : v + CntWidth'(1);
   endfunction

   assign valid_o   = valid_i;
   assign ready_o   = ready_i;
   assign payload_o = payload_i;

   always_comb begin
      state_d     = state_q;
      latched_d   = latched_q;
      transfers_d = transfers_q;
      stall_d     = stall_q;
      run_d       = run_q;
      max_d       = max_q;
      err_drop_d  = err_drop_q;
      err_chg_d   = err_chg_q;
      timeout_d   = timeout_q;
      stall_evt   = 1'b0;

      unique case (state_q)
         Idle: begin
            if (valid_i && ready_i) begin
               transfers_d = sat_inc(transfers_q);
            end else if (valid_i) begin
               latched_d = payload_i;
               run_d     = CntWidth'(1);
               stall_d   = sat_inc(stall_q);
               stall_evt = 1'b1;
               state_d   = Pending;
            end
         end
         Pending: begin
            if (!valid_i) begin
               err_drop_d = 1'b1;
               run_d      = '0;
               state_d    = Idle;
            end else begin
               // A payload change is flagged even on the cycle the beat finally transfers.
               if (!(payload_i == latched_q)) begin
                  err_chg_d = 1'b1;
                  latched_d = payload_i;
               end
               if (ready_i) begin
                  transfers_d = sat_inc(transfers_q);
                  run_d       = '0;
                  state_d     = Idle;
               end else begin
                  stall_d   = sat_inc(stall_q);
                  run_d     = sat_inc(run_q);
                  stall_evt = 1'b1;
               end
            end
         end
         default: state_d = Idle;
      endcase

      if (stall_evt) begin
         if (run_d > max_q) max_d = run_d;
         if (TimeoutCycles != 0 && {32'd0, run_d} == TimeoutExt) timeout_d = 1'b1;
      end

      // Clear overrides any same-cycle update but leaves the handshake tracking alone.
      if (clear_i) begin
         transfers_d = '0;
         stall_d     = '0;
         run_d       = '0;
         max_d       = '0;
         err_drop_d  = 1'b0;
         err_chg_d   = 1'b0;
         timeout_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= Idle;
         latched_q   <= '0;
         transfers_q <= '0;
         stall_q     <= '0;
         run_q       <= '0;
         max_q       <= '0;
         err_drop_q  <= 1'b0;
         err_chg_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         latched_q   <= latched_d;
         transfers_q <= transfers_d;
         stall_q     <= stall_d;
         run_q       <= run_d;
         max_q       <= max_d;
         err_drop_q  <= err_drop_d;
         err_chg_q   <= err_chg_d;
         timeout_q   <= timeout_d;
      end
   end

   assign transfers_o          = transfers_q;
   assign stall_cycles_o       = stall_q;
   assign max_stall_o          = max_q;
   assign err_valid_drop_o     = err_drop_q;
   assign err_payload_change_o = err_chg_q;
   assign timeout_o            = timeout_q;

endmodule

// File: tb/tb_stream_handshake_monitor.sv
// Scoreboard bench: a 32-bit-counter instance and a 2-bit saturating instance share stimulus.
module tb_stream_handshake_monitor;

   typedef logic [7:0] pl_t;

   typedef struct {
      bit     pend;
      pl_t    lat;
      longint xfer, stall, run, mx;
      bit     edrop, echg, tmo;
   } mdl_t;

   typedef struct {
      longint xa, sa, ma;
      bit     da, ca, ta;
      longint xb, sb, mb;
      bit     db, cb, tb;
   } exp_t;

   localparam longint LimA = 64'd4294967295;
   localparam longint LimB = 64'd3;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic clear_i = 1'b0;
   logic valid_i = 1'b0;
   logic ready_i = 1'b0;
   pl_t  payload_i = '0;

   logic        a_ready_o, a_valid_o, a_edrop, a_echg, a_tmo;
   pl_t         a_payload_o;
   logic [31:0] a_xfer, a_stall, a_max;
   logic        b_ready_o, b_valid_o, b_edrop, b_echg, b_tmo;
   pl_t         b_payload_o;
   logic [1:0]  b_xfer, b_stall, b_max;

   int total = 0;
   int bad   = 0;
   mdl_t ma, mb;
   exp_t q[$];

   always #5 clk = ~clk;

   stream_handshake_monitor #(.payload_t(pl_t), .CntWidth(32), .TimeoutCycles(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
      .valid_i(valid_i), .ready_o(a_ready_o), .payload_i(payload_i),
      .valid_o(a_valid_o), .ready_i(ready_i), .payload_o(a_payload_o),
      .transfers_o(a_xfer), .stall_cycles_o(a_stall), .max_stall_o(a_max),
      .err_valid_drop_o(a_edrop), .err_payload_change_o(a_echg), .timeout_o(a_tmo)
   );

   stream_handshake_monitor #(.payload_t(pl_t), .CntWidth(2), .TimeoutCycles(4)) u_sat (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
      .valid_i(valid_i), .ready_o(b_ready_o), .payload_i(payload_i),
      .valid_o(b_valid_o), .ready_i(ready_i), .payload_o(b_payload_o),
      .transfers_o(b_xfer), .stall_cycles_o(b_stall), .max_stall_o(b_max),
      .err_valid_drop_o(b_edrop), .err_payload_change_o(b_echg), .timeout_o(b_tmo)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic mdl_t mreset();
      mdl_t m;
      m.pend = 0; m.lat = '0; m.xfer = 0; m.stall = 0; m.run = 0; m.mx = 0;
      m.edrop = 0; m.echg = 0; m.tmo = 0;
      return m;
   endfunction

   function automatic longint inc(longint x, longint lim);
      return (x >= lim) ? lim : x + 1;
   endfunction

   // Reference behaviour of one clock edge.
   function automatic mdl_t step(mdl_t m, bit v, bit r, pl_t p, bit clr, longint lim);
      mdl_t n = m;
      bit   st = 0;
      if (!m.pend) begin
         if (v && r) n.xfer = inc(m.xfer, lim);
         else if (v) begin
            n.pend = 1; n.lat = p; n.run = 1; n.stall = inc(m.stall, lim); st = 1;
         end
      end else if (!v) begin
         n.edrop = 1; n.run = 0; n.pend = 0;
      end else begin
         if (p != m.lat) begin n.echg = 1; n.lat = p; end
         if (r) begin
            n.xfer = inc(m.xfer, lim); n.run = 0; n.pend = 0;
         end else begin
            n.stall = inc(m.stall, lim); n.run = inc(m.run, lim); st = 1;
         end
      end
      if (st) begin
         if (n.run > n.mx) n.mx = n.run;
         if (n.run == 4) n.tmo = 1;
      end
      if (clr) begin
         n.xfer = 0; n.stall = 0; n.run = 0; n.mx = 0; n.edrop = 0; n.echg = 0; n.tmo = 0;
      end
      return n;
   endfunction

   task automatic compare(input exp_t e);
      check("a_xfer", a_xfer, e.xa);   check("a_stall", a_stall, e.sa);
      check("a_max", a_max, e.ma);     check("a_drop", a_edrop, e.da);
      check("a_chg", a_echg, e.ca);    check("a_tmo", a_tmo, e.ta);
      check("b_xfer", b_xfer, e.xb);   check("b_stall", b_stall, e.sb);
      check("b_max", b_max, e.mb);     check("b_drop", b_edrop, e.db);
      check("b_chg", b_echg, e.cb);    check("b_tmo", b_tmo, e.tb);
   endtask

   // Called just after a rising edge; applies one cycle of stimulus.
   task automatic drive(input bit v, input bit r, input pl_t p, input bit clr);
      exp_t e;
      valid_i = v; ready_i = r; payload_i = p; clear_i = clr;
      #1;
      check("pass_valid", a_valid_o, v);
      check("pass_ready", a_ready_o, r);
      check("pass_data", a_payload_o, p);
      check("pass_data_b", b_payload_o, p);
      ma = step(ma, v, r, p, clr, LimA);
      mb = step(mb, v, r, p, clr, LimB);
      e.xa = ma.xfer; e.sa = ma.stall; e.ma = ma.mx; e.da = ma.edrop; e.ca = ma.echg; e.ta = ma.tmo;
      e.xb = mb.xfer; e.sb = mb.stall; e.mb = mb.mx; e.db = mb.edrop; e.cb = mb.echg; e.tb = mb.tmo;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) check("sb_empty", 1, 0);
      else compare(q.pop_front());
   endtask

   task automatic idle_clear();
      drive(0, 0, 8'h00, 1);
      drive(0, 1, 8'h00, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ma = mreset();
      mb = mreset();
      #12;
      check("rst_xfer", a_xfer, 0);
      check("rst_stall", a_stall, 0);
      check("rst_max", a_max, 0);
      check("rst_flags", {a_edrop, a_echg, a_tmo}, 0);
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      // 1: back-to-back beats
      for (int i = 0; i < 5; i++) drive(1, 1, pl_t'(8'h10 + i), 0);
      drive(0, 1, 8'h00, 0);
      check("t1_xfer", a_xfer, 5);
      check("t1_stall", a_stall, 0);
      check("t1_flags", {a_edrop, a_echg, a_tmo}, 0);
      idle_clear();

      // 2: three stall cycles then accept
      for (int i = 0; i < 3; i++) drive(1, 0, 8'h33, 0);
      drive(1, 1, 8'h33, 0);
      drive(0, 0, 8'h00, 0);
      check("t2_stall", a_stall, 3);
      check("t2_max", a_max, 3);
      check("t2_xfer", a_xfer, 1);
      idle_clear();

      // 3: valid dropped while pending
      drive(1, 0, 8'h44, 0);
      drive(0, 0, 8'h44, 0);
      drive(0, 1, 8'h00, 0);
      drive(0, 0, 8'h00, 0);
      check("t3_drop", a_edrop, 1);
      check("t3_xfer", a_xfer, 0);
      drive(0, 0, 8'h00, 1);
      check("t3_clr", a_edrop, 0);
      drive(0, 0, 8'h00, 0);

      // 4: payload change while stalled
      drive(1, 0, 8'hA5, 0);
      drive(1, 0, 8'h5A, 0);
      drive(1, 1, 8'h5A, 0);
      check("t4_chg", a_echg, 1);
      idle_clear();

      // 5: timeout threshold of 4
      for (int i = 0; i < 3; i++) drive(1, 0, 8'h77, 0);
      check("t5_tmo3", a_tmo, 0);
      drive(1, 1, 8'h77, 0);
      check("t5_tmo3b", a_tmo, 0);
      idle_clear();
      for (int i = 0; i < 4; i++) drive(1, 0, 8'h78, 0);
      check("t5_tmo4", a_tmo, 1);
      drive(1, 1, 8'h78, 0);
      idle_clear();

      // clear during a stall restarts the run
      drive(1, 0, 8'h90, 0);
      drive(1, 0, 8'h90, 0);
      drive(1, 0, 8'h90, 1);
      drive(1, 0, 8'h90, 0);
      check("clr_run_max", a_max, 1);
      drive(1, 1, 8'h90, 0);
      idle_clear();

      // 6: saturation and clear priority
      for (int i = 0; i < 5; i++) drive(1, 1, pl_t'(i), 0);
      check("t6_sat", b_xfer, 3);
      check("t6_wide", a_xfer, 5);
      drive(1, 1, 8'h55, 1);
      check("t6_clr", b_xfer, 0);
      drive(0, 0, 8'h00, 0);

      // async reset in the middle of a stall
      drive(1, 0, 8'hC3, 0);
      drive(1, 0, 8'hC3, 0);
      rst_ni = 1'b0;
      #2;
      check("arst_stall", a_stall, 0);
      check("arst_max", a_max, 0);
      check("arst_flags", {a_edrop, a_echg, a_tmo}, 0);
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      ma = mreset();
      mb = mreset();
      drive(1, 0, 8'hC4, 0);
      drive(1, 1, 8'hC4, 0);
      check("arst_after", a_max, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
